// File: rtl/piksel_paketleyici.sv
// piksel_fifo: small first-word-fall-through FIFO with synchronous flush
// Latency: a pushed word is visible at the head one cycle after the push edge
// Backpressure: a push into a full FIFO is accepted only when a pop happens in the same cycle, otherwise it is dropped and flagged on drop
module piksel_fifo #(
    parameter int W        = 32,
    parameter int DERINLIK = 4
) (
    input  logic         clk_i,
    input  logic         rstn_i,
    input  logic         flush,
    input  logic         push_vld,
    input  logic [W-1:0] push_dat,
    input  logic         pop_rdy,
    output logic         empty,
    output logic [W-1:0] head_dat,
    output logic         drop
);
    localparam int AW = $clog2(DERINLIK);

    logic [W-1:0] mem [DERINLIK];
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    logic         full;
    logic         do_pop;
    logic         do_push;

    // Extra pointer bit separates the full and empty cases when the indices match.
    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop   = pop_rdy && !empty && !flush;
    // A pop frees a slot in the same cycle, so a full FIFO still takes the push.
    assign do_push  = push_vld && !flush && (!full || do_pop);
    assign drop     = push_vld && !flush && full && !do_pop;
    assign head_dat = mem[rd_ptr[AW-1:0]];

    // Pointer update; flush returns both pointers to the empty position.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage write; contents are never observed while the FIFO is empty.
    always_ff @(posedge clk_i) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_dat;
    end
endmodule

// piksel_paketleyici: packs four filtered pixels per word and queues them in a FWFT FIFO
// Latency: a word is valid one cycle after its last lane (or the frame's final pixel) is captured
// Backpressure: veri_hazir_i low holds the head word; a word that meets a full FIFO is dropped and sets tasma_o
module piksel_paketleyici #(
    parameter int PIXEL_BIT     = 8,
    parameter int PIKSEL_SAYISI = 16,
    parameter int FIFO_DERINLIK = 4
) (
    input  logic                   clk_i,
    input  logic                   rstn_i,
    input  logic                   basla_i,
    input  logic                   etkin_i,
    input  logic [PIXEL_BIT-1:0]   pixel_i,
    input  logic                   veri_hazir_i,
    output logic                   veri_gecerli_o,
    output logic [4*PIXEL_BIT-1:0] veri_o,
    output logic                   tasma_o,
    output logic                   cerceve_bitti_o
);
    localparam int CW = $clog2(PIKSEL_SAYISI + 1);

    typedef enum logic [1:0] {
        BOSTA  = 2'd0,
        TOPLA  = 2'd1,
        BOSALT = 2'd2
    } durum_t;

    durum_t                 durum_q;
    logic [CW-1:0]          sayac_q;
    logic [1:0]             lane_q;
    logic [4*PIXEL_BIT-1:0] paket_q;
    logic [4*PIXEL_BIT-1:0] bekleyen_dat;
    logic                   bekleyen_vld;
    logic [4*PIXEL_BIT-1:0] word_w;
    logic                   son_piksel;
    logic                   fifo_empty;
    logic [4*PIXEL_BIT-1:0] fifo_head;
    logic                   fifo_drop;

    assign son_piksel = (sayac_q == CW'(PIKSEL_SAYISI - 1));

    // Pack register with the incoming pixel merged into the current lane.
    always_comb begin
        word_w = paket_q;
        for (int i = 0; i < 4; i++) begin
            if (lane_q == 2'(i)) word_w[i*PIXEL_BIT +: PIXEL_BIT] = pixel_i;
        end
    end

    // The completed word waits one cycle in bekleyen_dat so the pack register
    // can take the next lane 0 pixel without a bubble.
    piksel_fifo #(
        .W        (4*PIXEL_BIT),
        .DERINLIK (FIFO_DERINLIK)
    ) u_fifo (
        .clk_i    (clk_i),
        .rstn_i   (rstn_i),
        .flush    (basla_i),
        .push_vld (bekleyen_vld),
        .push_dat (bekleyen_dat),
        .pop_rdy  (veri_hazir_i),
        .empty    (fifo_empty),
        .head_dat (fifo_head),
        .drop     (fifo_drop)
    );

    assign veri_gecerli_o = !fifo_empty;
    assign veri_o         = fifo_empty ? '0 : fifo_head;

    // Frame control: start/abort, lane packing, overflow flag and frame-done pulse.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            durum_q         <= BOSTA;
            sayac_q         <= '0;
            lane_q          <= '0;
            paket_q         <= '0;
            bekleyen_dat    <= '0;
            bekleyen_vld    <= 1'b0;
            tasma_o         <= 1'b0;
            cerceve_bitti_o <= 1'b0;
        end else begin
            cerceve_bitti_o <= 1'b0;
            if (basla_i) begin
                // Start or abort: everything in flight is discarded, the pixel
                // presented in this cycle is not captured.
                durum_q      <= TOPLA;
                sayac_q      <= '0;
                lane_q       <= '0;
                paket_q      <= '0;
                bekleyen_dat <= '0;
                bekleyen_vld <= 1'b0;
                tasma_o      <= 1'b0;
            end else begin
                if (fifo_drop) tasma_o <= 1'b1;
                // A pending word is consumed (or dropped) by the FIFO this cycle.
                bekleyen_vld <= 1'b0;
                case (durum_q)
                    TOPLA: begin
                        if (etkin_i) begin
                            sayac_q <= sayac_q + CW'(1);
                            if (lane_q == 2'd3 || son_piksel) begin
                                bekleyen_dat <= word_w;
                                bekleyen_vld <= 1'b1;
                                paket_q      <= '0;
                                lane_q       <= '0;
                            end else begin
                                paket_q <= word_w;
                                lane_q  <= lane_q + 2'd1;
                            end
                            if (son_piksel) durum_q <= BOSALT;
                        end
                    end
                    BOSALT: begin
                        if (fifo_empty && !bekleyen_vld) begin
                            cerceve_bitti_o <= 1'b1;
                            durum_q         <= BOSTA;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule
